xxv_mac_init_sequencer: RTL and testbench
=========================================

Name: xxv_mac_init_sequencer

Overview:
Hardware bring-up sequencer for one 10/25G XXV MAC core. It acts as an AXI4-Lite master into the MAC register window and performs a fixed programme: write the configuration registers, pulse the GT reset, poll STAT_RX_BLOCK_LOCK, then enable TX. It sits between the shell's reset controller and the MAC AXI-Lite slave, replacing host-driven bring-up, and reports busy/done/error to the shell register file.

Parameters:
MODE_VAL, 32'hC000_0000, value written to MODE_REG (0x008).
RX_CFG_VAL, 32'h0000_0001, value written to CONFIGURATION_RX_REG1 (0x014).
TX_CFG_VAL, 32'h0000_0000, initial value written to CONFIGURATION_TX_REG1 (0x00C).
TX_EN_VAL, 32'h0000_0001, value written to 0x00C after lock.
POLL_INTERVAL, 1024, idle cycles between lock polls (>=1).
MAX_POLLS, 4096, maximum number of lock reads before error (>=1).

Ports:
axil_aclk  in  1  AXI-Lite clock; single clock domain.
mod_rstn  in  1  asynchronous active-low reset.
start  in  1  single-cycle pulse; starts the sequence.
busy  out  1  high while the sequence runs.
done  out  1  sticky; sequence completed.
error  out  1  sticky; bad response or timeout.
err_code  out  2  0 none, 1 SLVERR/DECERR on write, 2 SLVERR/DECERR on read, 3 poll timeout.
lock_status  out  32  last data read from 0x40C.
m_axil_awvalid/awready  out/in  1  write address handshake.
m_axil_awaddr  out  12  MAC register offset.
m_axil_wvalid/wready  out/in  1  write data handshake.
m_axil_wdata  out  32  write data; m_axil_wstrb (out, 4) is always 4'hF.
m_axil_bvalid/bready  in/out  1  write response handshake.
m_axil_bresp  in  2  write response.
m_axil_arvalid/arready  out/in  1  read address handshake.
m_axil_araddr  out  12  read offset.
m_axil_rvalid/rready  in/out  1  read data handshake.
m_axil_rdata  in  32  read data.
m_axil_rresp  in  2  read response.

Behaviour:
- Reset:
  - State IDLE; all valid/ready outputs 0; busy, done, error 0; err_code 0; lock_status 0; addresses and data 0.
  - Reset asserted mid-transaction aborts immediately. No completion of the outstanding AXI beat is attempted.
- Write programme (step 0..5):
  - (0x008, MODE_VAL), (0x014, RX_CFG_VAL), (0x00C, TX_CFG_VAL), (0x000, 1), (0x000, 0), then the lock poll, then (0x00C, TX_EN_VAL).
- States:
  - IDLE: on start, go to WR. Clear done, error and err_code; set busy; step = 0.
  - WR: assert awvalid and wvalid together in the same cycle. Each is dropped independently on its own handshake, and may complete in either order or in the same cycle. Address and data are held stable while valid. When both have completed, go to WR_RESP.
  - WR_RESP: bready = 1. On bvalid:
    - bresp != 0: go to ERROR with err_code 1.
    - otherwise advance. After step 4 go to RD; after the TX-enable write go to DONE.
  - RD: arvalid with araddr 0x40C until arready, then go to RD_DATA.
  - RD_DATA: rready = 1. On rvalid, latch lock_status = rdata and increment the poll count (width clog2(MAX_POLLS+1)).
    - rresp != 0: go to ERROR with err_code 2.
    - rdata != 0: go to WR for the TX-enable step.
    - poll count == MAX_POLLS: go to ERROR with err_code 3.
    - otherwise go to POLL_WAIT.
  - POLL_WAIT: count POLL_INTERVAL cycles, then go to RD. The poll count resets to 0 on each start.
  - DONE: done = 1, busy = 0.
  - ERROR: error = 1, busy = 0.
- start handling: start in DONE or ERROR re-runs the sequence from step 0 (same as IDLE). start while busy is ignored.
- Bus discipline: at most one outstanding AXI transaction. Read and write channels are never active simultaneously. Handshake-in-same-cycle-as-valid-assert is legal (zero-wait slave).
- Latency: with a zero-wait slave, each write costs 3 cycles (WR, WR_RESP, transition) and each read 2 cycles. No combinational path from inputs to valid outputs.

Test Plan:
1. Zero-wait slave, lock register returns 0 for 2 reads then 1 -> exact write order 008=C0000000, 014=1, 00C=0, 000=1, 000=0, then 3 reads of 40C, then 00C=1. done=1, busy=0, lock_status=1, poll spacing = POLL_INTERVAL cycles.
2. Slave stalls awready 5 cycles and wready 2 cycles (and the reverse) -> awaddr/wdata stable throughout, single beat each, sequence still completes.
3. bresp=2'b10 on the GT_RESET=1 write -> ERROR, err_code=1, no further AXI activity, busy=0.
4. MAX_POLLS=4, lock always 0 -> exactly 4 reads, then error=1, err_code=3; a subsequent start re-runs from 0x008.
5. start pulsed while busy -> ignored; reset asserted during RD_DATA -> all outputs return to reset values; a start after reset completes normally.
6. rresp=2'b11 on the first poll -> error, err_code=2, lock_status updated to that beat's rdata.

Source files
------------

// File: rtl/xxv_mac_init_sequencer_if.sv
//------------------------------------------------------------------------------
// Module     : xxv_mac_init_sequencer_if
// Description: AXI4-Lite bundle between the bring-up sequencer (master) and
//              the XXV MAC register window (slave). 12-bit register offsets,
//              32-bit data.
//              Write address : awvalid/awready/awaddr
//              Write data    : wvalid/wready/wdata/wstrb
//              Write response: bvalid/bready/bresp
//              Read address  : arvalid/arready/araddr
//              Read data     : rvalid/rready/rdata/rresp
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface xxv_mac_init_sequencer_if;
    logic        awvalid;
    logic        awready;
    logic [11:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [11:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

`default_nettype wire

// File: rtl/xxv_mac_init_sequencer.sv
//------------------------------------------------------------------------------
// Module     : xxv_mac_init_sequencer
// Description: Bring-up sequencer for one 10/25G XXV MAC. Acts as AXI4-Lite
//              master: writes MODE/RX/TX configuration, pulses GT reset,
//              polls STAT_RX_BLOCK_LOCK (0x40C) until non-zero, then enables
//              TX. Reports busy/done/error to the shell.
// Ports      : axil_aclk   - AXI-Lite clock
//              mod_rstn    - asynchronous active-low reset
//              start       - single-cycle pulse, (re)starts the programme
//              busy        - programme running
//              done        - sticky, programme completed
//              error       - sticky, bad response or poll timeout
//              err_code    - 0 none, 1 write resp, 2 read resp, 3 timeout
//              lock_status - last data read from 0x40C
//              m_axil      - AXI4-Lite master port (interface)
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module xxv_mac_init_sequencer #(
    parameter logic [31:0] MODE_VAL      = 32'hC000_0000,
    parameter logic [31:0] RX_CFG_VAL    = 32'h0000_0001,
    parameter logic [31:0] TX_CFG_VAL    = 32'h0000_0000,
    parameter logic [31:0] TX_EN_VAL     = 32'h0000_0001,
    parameter int unsigned POLL_INTERVAL = 1024,
    parameter int unsigned MAX_POLLS     = 4096
) (
    input  logic                     axil_aclk,
    input  logic                     mod_rstn,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [1:0]               err_code,
    output logic [31:0]              lock_status,
    xxv_mac_init_sequencer_if.master m_axil
);

    localparam int c_PCNT_W = $clog2(MAX_POLLS + 1);
    localparam int c_WAIT_W = $clog2(POLL_INTERVAL + 1);

    localparam logic [11:0] c_LOCK_ADDR = 12'h40C;

    // Step indices into the write programme; the lock poll sits between
    // the last configuration write and the TX-enable write.
    localparam logic [2:0] c_STEP_LAST_CFG = 3'd4;
    localparam logic [2:0] c_STEP_TX_EN    = 3'd5;

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_WR        = 3'd1;
    localparam logic [2:0] c_WR_RESP   = 3'd2;
    localparam logic [2:0] c_RD        = 3'd3;
    localparam logic [2:0] c_RD_DATA   = 3'd4;
    localparam logic [2:0] c_POLL_WAIT = 3'd5;
    localparam logic [2:0] c_DONE      = 3'd6;
    localparam logic [2:0] c_ERROR     = 3'd7;

    logic [2:0]          r_state;
    logic [2:0]          r_step;
    logic [c_PCNT_W-1:0] r_poll_cnt;
    logic [c_WAIT_W-1:0] r_wait_cnt;

    logic                r_busy;
    logic                r_done;
    logic                r_error;
    logic [1:0]          r_err_code;
    logic [31:0]         r_lock_status;

    logic                r_awvalid;
    logic [11:0]         r_awaddr;
    logic                r_wvalid;
    logic [31:0]         r_wdata;
    logic                r_bready;
    logic                r_arvalid;
    logic [11:0]         r_araddr;
    logic                r_rready;

    logic                w_aw_done;
    logic                w_w_done;
    logic [2:0]          w_step_next;
    logic [c_PCNT_W-1:0] w_poll_next;

    // Register offset and data for each write step, packed {addr, data}.
    function automatic logic [43:0] f_step(input logic [2:0] step);
        case (step)
            3'd0:    f_step = {12'h008, MODE_VAL};
            3'd1:    f_step = {12'h014, RX_CFG_VAL};
            3'd2:    f_step = {12'h00C, TX_CFG_VAL};
            3'd3:    f_step = {12'h000, 32'h0000_0001};
            3'd4:    f_step = {12'h000, 32'h0000_0000};
            default: f_step = {12'h00C, TX_EN_VAL};
        endcase
    endfunction

    // A channel counts as complete once its valid has been dropped or is
    // being accepted this cycle; AW and W may finish in either order.
    always_comb begin
        w_aw_done   = !r_awvalid || m_axil.awready;
        w_w_done    = !r_wvalid  || m_axil.wready;
        w_step_next = r_step + 3'd1;
        w_poll_next = r_poll_cnt + 1'b1;
    end

    always_ff @(posedge axil_aclk or negedge mod_rstn) begin
        if (!mod_rstn) begin
            r_state       <= c_IDLE;
            r_step        <= 3'd0;
            r_poll_cnt    <= '0;
            r_wait_cnt    <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_err_code    <= 2'd0;
            r_lock_status <= 32'h0;
            r_awvalid     <= 1'b0;
            r_awaddr      <= 12'h0;
            r_wvalid      <= 1'b0;
            r_wdata       <= 32'h0;
            r_bready      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_araddr      <= 12'h0;
            r_rready      <= 1'b0;
        end else begin
            case (r_state)
                // DONE and ERROR hold their sticky flags but accept a
                // restart exactly like IDLE.
                c_IDLE, c_DONE, c_ERROR: begin
                    if (start) begin
                        r_state               <= c_WR;
                        r_step                <= 3'd0;
                        r_poll_cnt            <= '0;
                        r_busy                <= 1'b1;
                        r_done                <= 1'b0;
                        r_error               <= 1'b0;
                        r_err_code            <= 2'd0;
                        {r_awaddr, r_wdata}   <= f_step(3'd0);
                        r_awvalid             <= 1'b1;
                        r_wvalid              <= 1'b1;
                    end
                end

                c_WR: begin
                    if (r_awvalid && m_axil.awready) begin
                        r_awvalid <= 1'b0;
                    end
                    if (r_wvalid && m_axil.wready) begin
                        r_wvalid <= 1'b0;
                    end
                    if (w_aw_done && w_w_done) begin
                        r_state  <= c_WR_RESP;
                        r_bready <= 1'b1;
                    end
                end

                c_WR_RESP: begin
                    if (m_axil.bvalid) begin
                        r_bready <= 1'b0;
                        if (m_axil.bresp != 2'b00) begin
                            r_state    <= c_ERROR;
                            r_error    <= 1'b1;
                            r_err_code <= 2'd1;
                            r_busy     <= 1'b0;
                        end else if (r_step == c_STEP_LAST_CFG) begin
                            r_state   <= c_RD;
                            r_arvalid <= 1'b1;
                            r_araddr  <= c_LOCK_ADDR;
                        end else if (r_step == c_STEP_TX_EN) begin
                            r_state <= c_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state             <= c_WR;
                            r_step              <= w_step_next;
                            {r_awaddr, r_wdata} <= f_step(w_step_next);
                            r_awvalid           <= 1'b1;
                            r_wvalid            <= 1'b1;
                        end
                    end
                end

                c_RD: begin
                    if (m_axil.arready) begin
                        r_state   <= c_RD_DATA;
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                    end
                end

                c_RD_DATA: begin
                    if (m_axil.rvalid) begin
                        r_rready      <= 1'b0;
                        r_lock_status <= m_axil.rdata;
                        r_poll_cnt    <= w_poll_next;
                        if (m_axil.rresp != 2'b00) begin
                            r_state    <= c_ERROR;
                            r_error    <= 1'b1;
                            r_err_code <= 2'd2;
                            r_busy     <= 1'b0;
                        end else if (m_axil.rdata != 32'h0) begin
                            r_state             <= c_WR;
                            r_step              <= c_STEP_TX_EN;
                            {r_awaddr, r_wdata} <= f_step(c_STEP_TX_EN);
                            r_awvalid           <= 1'b1;
                            r_wvalid            <= 1'b1;
                        end else if (w_poll_next == c_PCNT_W'(MAX_POLLS)) begin
                            r_state    <= c_ERROR;
                            r_error    <= 1'b1;
                            r_err_code <= 2'd3;
                            r_busy     <= 1'b0;
                        end else begin
                            r_state    <= c_POLL_WAIT;
                            r_wait_cnt <= '0;
                        end
                    end
                end

                // Bus stays idle for exactly POLL_INTERVAL cycles before
                // the next read address is presented.
                c_POLL_WAIT: begin
                    if (r_wait_cnt == c_WAIT_W'(POLL_INTERVAL - 1)) begin
                        r_state    <= c_RD;
                        r_wait_cnt <= '0;
                        r_arvalid  <= 1'b1;
                        r_araddr   <= c_LOCK_ADDR;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;
    assign err_code    = r_err_code;
    assign lock_status = r_lock_status;

    assign m_axil.awvalid = r_awvalid;
    assign m_axil.awaddr  = r_awaddr;
    assign m_axil.wvalid  = r_wvalid;
    assign m_axil.wdata   = r_wdata;
    assign m_axil.wstrb   = 4'hF;
    assign m_axil.bready  = r_bready;
    assign m_axil.arvalid = r_arvalid;
    assign m_axil.araddr  = r_araddr;
    assign m_axil.rready  = r_rready;

endmodule

`default_nettype wire

// File: tb/tb_xxv_mac_init_sequencer.sv
//------------------------------------------------------------------------------
// Module     : tb_xxv_mac_init_sequencer
// Description: Self-checking bench for xxv_mac_init_sequencer. An AXI-Lite
//              slave responder with configurable stalls and error injection
//              answers the DUT; a programme-level model predicts the write
//              list, read count, final flags and lock_status of each run.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_xxv_mac_init_sequencer;

    localparam int c_PI = 6;
    localparam int c_MP = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, error;
    logic [1:0]  err_code;
    logic [31:0] lock_status;

    xxv_mac_init_sequencer_if bus();

    xxv_mac_init_sequencer #(
        .POLL_INTERVAL (c_PI),
        .MAX_POLLS     (c_MP)
    ) dut (
        .axil_aclk   (clk),
        .mod_rstn    (rst_n),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .err_code    (err_code),
        .lock_status (lock_status),
        .m_axil      (bus)
    );

    always #5 clk = ~clk;

    // Expected programme: config writes 0..4, TX enable at index 5.
    logic [11:0] prog_a [0:5] = '{12'h008, 12'h014, 12'h00C, 12'h000, 12'h000, 12'h00C};
    logic [31:0] prog_d [0:5] = '{32'hC000_0000, 32'h1, 32'h0, 32'h1, 32'h0, 32'h1};

    int checks = 0;
    int errors = 0;

    // Slave configuration
    int aw_stall = 0, w_stall = 0, b_stall = 0, ar_stall = 0, r_stall = 0;
    int bad_wr = -1, bad_rd = -1, lock_after = 1;
    logic [31:0] lock_val = 32'h1, bad_rdata = 32'h0;

    // Slave observations
    int cycle = 0;
    logic [11:0] wa_q [$];
    logic [31:0] wd_q [$];
    int gap_q [$];
    int aw_beats = 0, w_beats = 0, ar_beats = 0, proto_err = 0;
    int last_r_cycle = -1;
    logic [31:0] model_lock = 32'h0;

    function automatic logic [31:0] rd_data(input int k);
        if (k == bad_rd)      return bad_rdata;
        if (k >= lock_after)  return lock_val;
        return 32'h0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // AXI-Lite slave responder. At each falling edge it first accounts for
    // handshakes at the rising edge just passed (using the snapshot taken
    // one negedge earlier), then drives the next ready/valid values.
    initial begin : slave
        logic s_awv, s_wv, s_arv, s_bready, s_rready;
        logic [11:0] s_awaddr, s_araddr, cur_addr;
        logic [31:0] s_wdata, cur_data;
        bit got_aw, got_w, b_pend, r_pend;
        int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
        {s_awv, s_wv, s_arv, s_bready, s_rready} = '0;
        s_awaddr = '0; s_araddr = '0; s_wdata = '0; cur_addr = '0; cur_data = '0;
        {got_aw, got_w, b_pend, r_pend} = '0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
        bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;
        forever begin
            @(negedge clk);
            cycle++;
            if (!rst_n) begin
                {s_awv, s_wv, s_arv, s_bready, s_rready} = '0;
                {got_aw, got_w, b_pend, r_pend} = '0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
                bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
                bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;
                continue;
            end
            // handshakes completed at the last rising edge
            if (s_awv && bus.awready) begin
                got_aw = 1; cur_addr = s_awaddr; aw_beats++;
            end else if (s_awv && (bus.awvalid !== 1'b1 || bus.awaddr !== s_awaddr)) begin
                proto_err++;
            end
            if (s_wv && bus.wready) begin
                got_w = 1; cur_data = s_wdata; w_beats++;
                if (bus.wstrb !== 4'hF) proto_err++;
            end else if (s_wv && (bus.wvalid !== 1'b1 || bus.wdata !== s_wdata)) begin
                proto_err++;
            end
            if (bus.bvalid && s_bready) begin
                bus.bvalid = 0; bus.bresp = 0;
            end
            if (s_arv && bus.arready) begin
                ar_beats++; r_pend = 1; r_cnt = 0;
                if (s_araddr !== 12'h40C) proto_err++;
            end else if (s_arv && (bus.arvalid !== 1'b1 || bus.araddr !== s_araddr)) begin
                proto_err++;
            end
            if (bus.rvalid && s_rready) begin
                bus.rvalid = 0; bus.rresp = 0; last_r_cycle = cycle;
            end
            if ((bus.awvalid || bus.wvalid || bus.bready) && (bus.arvalid || bus.rready))
                proto_err++;
            if (bus.arvalid && !s_arv && last_r_cycle >= 0)
                gap_q.push_back(cycle - last_r_cycle);
            if (got_aw && got_w) begin
                wa_q.push_back(cur_addr); wd_q.push_back(cur_data);
                got_aw = 0; got_w = 0; b_pend = 1; b_cnt = 0;
            end
            // drive next values
            if (!bus.awvalid || got_aw) begin bus.awready = 0; aw_cnt = 0; end
            else if (!bus.awready) begin
                if (aw_cnt >= aw_stall) bus.awready = 1; else aw_cnt++;
            end
            if (!bus.wvalid || got_w) begin bus.wready = 0; w_cnt = 0; end
            else if (!bus.wready) begin
                if (w_cnt >= w_stall) bus.wready = 1; else w_cnt++;
            end
            if (!bus.arvalid) begin bus.arready = 0; ar_cnt = 0; end
            else if (!bus.arready) begin
                if (ar_cnt >= ar_stall) bus.arready = 1; else ar_cnt++;
            end
            if (b_pend) begin
                if (b_cnt >= b_stall) begin
                    bus.bvalid = 1;
                    bus.bresp  = (wa_q.size() - 1 == bad_wr) ? 2'b10 : 2'b00;
                    b_pend = 0;
                end else b_cnt++;
            end
            if (r_pend) begin
                if (r_cnt >= r_stall) begin
                    bus.rvalid = 1;
                    bus.rdata  = rd_data(ar_beats);
                    bus.rresp  = (ar_beats == bad_rd) ? 2'b11 : 2'b00;
                    r_pend = 0;
                end else r_cnt++;
            end
            s_awv = bus.awvalid; s_wv = bus.wvalid; s_arv = bus.arvalid;
            s_bready = bus.bready; s_rready = bus.rready;
            s_awaddr = bus.awaddr; s_wdata = bus.wdata; s_araddr = bus.araddr;
        end
    end

    task automatic set_cfg(input int aw, input int w, input int b, input int ar, input int r,
                           input int la, input int bw, input int br);
        aw_stall = aw; w_stall = w; b_stall = b; ar_stall = ar; r_stall = r;
        lock_after = la; bad_wr = bw; bad_rd = br;
    endtask

    task automatic clear_logs();
        wa_q.delete(); wd_q.delete(); gap_q.delete();
        aw_beats = 0; w_beats = 0; ar_beats = 0; proto_err = 0; last_r_cycle = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " busy"}, {31'h0, busy}, 32'h0);
        chk({tag, " done"}, {31'h0, done}, 32'h0);
        chk({tag, " error"}, {31'h0, error}, 32'h0);
        chk({tag, " err_code"}, {30'h0, err_code}, 32'h0);
        chk({tag, " lock_status"}, lock_status, 32'h0);
        chk({tag, " valids"}, {27'h0, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 32'h0);
        chk({tag, " addr_data"}, {8'h0, bus.awaddr, bus.araddr} | bus.wdata, 32'h0);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Predict the run from the programme rules, launch it and compare.
    task automatic run_seq(input string tag, input bit mid_start);
        logic [11:0] ea [$];
        logic [31:0] ed [$];
        int e_reads, t;
        bit e_err, fin;
        logic [1:0] e_code;
        fin = 0; e_err = 0; e_code = 0; e_reads = 0;
        for (int i = 0; i < 5 && !fin; i++) begin
            ea.push_back(prog_a[i]); ed.push_back(prog_d[i]);
            if (bad_wr == i) begin e_err = 1; e_code = 2'd1; fin = 1; end
        end
        for (int k = 1; k <= c_MP && !fin; k++) begin
            e_reads = k;
            model_lock = rd_data(k);
            if (k == bad_rd) begin
                e_err = 1; e_code = 2'd2; fin = 1;
            end else if (model_lock != 0) begin
                ea.push_back(prog_a[5]); ed.push_back(prog_d[5]);
                if (bad_wr == 5) begin e_err = 1; e_code = 2'd1; end
                fin = 1;
            end else if (k == c_MP) begin
                e_err = 1; e_code = 2'd3; fin = 1;
            end
        end

        @(negedge clk);
        clear_logs();
        pulse_start();
        chk({tag, " busy_after_start"}, {31'h0, busy}, 32'h1);
        if (mid_start) begin
            repeat (6) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        t = 0;
        while (!(done || error) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, " finished_in_time"}, {31'h0, (t < 3000)}, 32'h1);
        repeat (20) @(negedge clk);

        chk({tag, " done"}, {31'h0, done}, {31'h0, !e_err});
        chk({tag, " error"}, {31'h0, error}, {31'h0, e_err});
        chk({tag, " err_code"}, {30'h0, err_code}, {30'h0, e_code});
        chk({tag, " busy_end"}, {31'h0, busy}, 32'h0);
        chk({tag, " lock_status"}, lock_status, model_lock);
        chk({tag, " wr_count"}, wa_q.size(), ea.size());
        chk({tag, " aw_beats"}, aw_beats, ea.size());
        chk({tag, " w_beats"}, w_beats, ea.size());
        for (int i = 0; i < ea.size() && i < wa_q.size(); i++) begin
            chk($sformatf("%s wr%0d_addr", tag, i), {20'h0, wa_q[i]}, {20'h0, ea[i]});
            chk($sformatf("%s wr%0d_data", tag, i), wd_q[i], ed[i]);
        end
        chk({tag, " reads"}, ar_beats, e_reads);
        chk({tag, " gap_count"}, gap_q.size(), (e_reads > 0) ? e_reads - 1 : 0);
        foreach (gap_q[i])
            chk($sformatf("%s poll_gap%0d", tag, i), gap_q[i], c_PI);
        chk({tag, " protocol"}, proto_err, 0);
    endtask

    initial begin : stim
        int t;
        #3;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1: zero-wait slave, lock on third read
        set_cfg(0, 0, 0, 0, 0, 3, -1, -1);
        lock_val = 32'h1;
        run_seq("t1", 0);

        // 2: AW/W stalls in both orders
        set_cfg(5, 2, 1, 1, 1, 1, -1, -1);
        run_seq("t2a", 0);
        set_cfg(2, 5, 0, 0, 2, 2, -1, -1);
        run_seq("t2b", 0);

        // 3: SLVERR on the GT_RESET=1 write
        set_cfg(0, 0, 0, 0, 0, 1, 3, -1);
        run_seq("t3", 0);

        // 4: lock never comes, then a clean re-run from 0x008
        set_cfg(0, 0, 0, 0, 0, 99, -1, -1);
        run_seq("t4", 0);
        set_cfg(0, 0, 0, 0, 0, 2, -1, -1);
        run_seq("t4_rerun", 0);

        // 5: start while busy is ignored
        set_cfg(1, 1, 1, 0, 0, 2, -1, -1);
        run_seq("t5_busy_start", 1);

        // 5: reset while waiting for read data
        set_cfg(0, 0, 0, 0, 40, 1, -1, -1);
        @(negedge clk);
        clear_logs();
        pulse_start();
        t = 0;
        while (!bus.rready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("t5 reached_rd_data", {31'h0, bus.rready}, 32'h1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("t5_mid_reset");
        model_lock = 32'h0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        set_cfg(0, 0, 0, 0, 0, 1, -1, -1);
        lock_val = 32'h0000_0003;
        run_seq("t5_after_reset", 0);

        // 6: DECERR-class rresp on the first poll
        set_cfg(0, 0, 0, 0, 0, 1, -1, 1);
        bad_rdata = 32'hA5A5_0000 | 32'($urandom_range(0, 255));
        run_seq("t6", 0);

        // randomized runs
        for (int n = 0; n < 6; n++) begin
            set_cfg(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(1, 5)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1,
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : -1);
            lock_val  = $urandom | 32'h1;
            bad_rdata = $urandom;
            run_seq($sformatf("rnd%0d", n), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
